// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: gathers W qualified serial bits (LSB- or MSB-first)
// into a word and hands it out through a one-entry valid/ready buffer.
module shift_deser #(
  parameter int W  = 8,
  parameter int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_in,
  input  logic          s_valid,
  input  logic          dir_sel,
  input  logic          clear,
  output logic [W-1:0]  p_out,
  output logic          p_valid,
  input  logic          p_ready,
  output logic          busy,
  output logic [CW-1:0] bit_cnt,
  output logic          overrun
);

  localparam logic [0:0] BUF_EMPTY = 1'b0;
  localparam logic [0:0] BUF_FULL  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [W-1:0]  p_out_q, p_out_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic          word_dir_q, word_dir_d;
  logic          overrun_q, overrun_d;
  logic          busy_q, busy_d;

  logic          cur_dir;
  logic          complete;
  logic          consume;
  logic [W-1:0]  next_sh;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BUF_EMPTY;
      sh_q       <= '0;
      p_out_q    <= '0;
      bit_cnt_q  <= '0;
      word_dir_q <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      p_out_q    <= p_out_d;
      bit_cnt_q  <= bit_cnt_d;
      word_dir_q <= word_dir_d;
      overrun_q  <= overrun_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic: bit collection, then output buffer handling
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    p_out_d    = p_out_q;
    bit_cnt_d  = bit_cnt_q;
    word_dir_d = word_dir_q;
    overrun_d  = overrun_q;
    complete   = 1'b0;

    // Direction is taken from dir_sel only on the first bit of a word
    cur_dir = (bit_cnt_q == '0) ? dir_sel : word_dir_q;
    next_sh = cur_dir ? {s_in, sh_q[W-1:1]} : {sh_q[W-2:0], s_in};
    consume = (state_q == BUF_FULL) && p_ready;

    if (clear) begin
      bit_cnt_d = '0;
      overrun_d = 1'b0;
      sh_d      = '0;
    end else if (s_valid) begin
      word_dir_d = cur_dir;
      sh_d       = next_sh;
      if (bit_cnt_q == CW'(W - 1)) begin
        bit_cnt_d = '0;
        complete  = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end

    case (state_q)
      BUF_EMPTY: begin
        if (complete) begin
          p_out_d = next_sh;
          state_d = BUF_FULL;
        end
      end
      BUF_FULL: begin
        if (complete && consume) begin
          p_out_d = next_sh;
        end else if (complete) begin
          overrun_d = 1'b1;
        end else if (consume) begin
          state_d = BUF_EMPTY;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase

    busy_d = (bit_cnt_d != '0);
  end

  assign p_out   = p_out_q;
  assign p_valid = (state_q == BUF_FULL);
  assign bit_cnt = bit_cnt_q;
  assign overrun = overrun_q;
  assign busy    = busy_q;

endmodule
